// File: rtl/ht16d35a_pkg.sv
// ht16d35a_pkg: shared types, defaults and chunk sizing for the HT16D35A frame writer
package ht16d35a_pkg;
  localparam logic [7:0] WRITE_CMD_DEF = 8'h80;
  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT_ACK, WAIT_DONE, DONE} fw_state_t;
  function automatic int chunk_len(input int rem, input int d);
    return rem < d ? rem : d;
  endfunction
endpackage

// File: rtl/ht16d35a_frame_writer.sv
// ht16d35a_frame_writer: splits a framebuffer frame into HT16D35A display-RAM write transactions
module ht16d35a_frame_writer
  import ht16d35a_pkg::*;
#(
  parameter int NUM_SELECTS = 2,
  parameter int OUT_BYTES = 8,
  parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES),
  parameter int FB_BYTES = 32,
  parameter int FB_ADDR_SZ = $clog2(FB_BYTES),
  parameter logic [7:0] WRITE_CMD = WRITE_CMD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_SELECTS-1:0]  target_cs,
  output logic                    wr_busy,
  output logic                    done,
  output logic                    fb_rd,
  output logic [FB_ADDR_SZ-1:0]   fb_addr,
  input  logic [7:0]              fb_data,
  output logic                    activate,
  output logic [NUM_SELECTS-1:0]  in_cs,
  output logic [7:0]              out_data [OUT_BYTES],
  output logic [OUT_BYTES_SZ-1:0] out_count,
  input  logic                    spi_busy
);
  localparam int D = OUT_BYTES - 2;
  localparam int IW = FB_ADDR_SZ + 1;
  fw_state_t st_q, st_d;
  logic [IW-1:0] idx_q, idx_d, rcnt_q, rcnt_d, ccnt_q, ccnt_d, n;
  logic [NUM_SELECTS-1:0] cs_q, cs_d;
  logic [OUT_BYTES_SZ-1:0] cnt_q, cnt_d;
  logic [7:0] buf_q [OUT_BYTES];
  logic [7:0] buf_d [OUT_BYTES];
  logic cap_q;
  assign n = IW'(chunk_len(FB_BYTES - int'(idx_q), D));
  assign fb_addr = fb_rd ? FB_ADDR_SZ'(idx_q + rcnt_q) : '0;
  assign wr_busy = st_q != IDLE && st_q != DONE;
  assign in_cs = cs_q;
  assign out_count = cnt_q;
  assign out_data = buf_q;
  // state, counters and transaction buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      idx_q <= '0;
      rcnt_q <= '0;
      ccnt_q <= '0;
      cs_q <= '0;
      cnt_q <= '0;
      buf_q <= '{default: '0};
      cap_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      rcnt_q <= rcnt_d;
      ccnt_q <= ccnt_d;
      cs_q <= cs_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      cap_q <= fb_rd;
    end
  end
  // sequencing: fetch a chunk, hand it to the controller, wait out its busy window
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    rcnt_d = rcnt_q;
    ccnt_d = ccnt_q;
    cs_d = cs_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    fb_rd = 1'b0;
    activate = 1'b0;
    done = 1'b0;
    case (st_q)
      IDLE: if (start) begin
        st_d = FETCH;
        cs_d = target_cs;
        idx_d = '0;
        rcnt_d = '0;
        ccnt_d = '0;
      end
      FETCH: begin
        fb_rd = rcnt_q < n;
        if (fb_rd) rcnt_d = rcnt_q + 1'b1;
        if (cap_q) begin
          ccnt_d = ccnt_q + 1'b1;
          for (int k = 2; k < OUT_BYTES; k++) if (int'(ccnt_q) + 2 == k) buf_d[k] = fb_data;
          if (ccnt_q == n - 1'b1) begin
            st_d = LAUNCH;
            cnt_d = OUT_BYTES_SZ'(n + 1'b1);
            buf_d[0] = WRITE_CMD;
            buf_d[1] = 8'(idx_q);
          end
        end
      end
      LAUNCH: if (!spi_busy) begin
        activate = 1'b1;
        st_d = WAIT_ACK;
      end
      WAIT_ACK: if (spi_busy) st_d = WAIT_DONE;
      WAIT_DONE: if (!spi_busy) begin
        idx_d = idx_q + n;
        rcnt_d = '0;
        ccnt_d = '0;
        st_d = int'(idx_d) >= FB_BYTES ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ht16d35a_frame_writer.sv
// tb_ht16d35a_frame_writer: table-driven and randomized checks of the frame writer against a chunking model
module tb_ht16d35a_frame_writer;
  typedef struct packed {logic [1:0] cs; logic [2:0] cnt; logic [63:0] d;} txn_t;
  typedef struct {int bl; logic [1:0] cs; bit rnd; bit inject; int n_a; int n_b;} vec_t;
  logic clk = 0;
  logic reset = 1, start = 0, hold_busy = 0;
  logic [1:0] target_cs = 0;
  int checks = 0, errors = 0, bl = 20, bc_a = 0, bc_b = 0, done_n_a = 0, done_n_b = 0;
  logic [7:0] mem [32];
  txn_t log_a[$], log_b[$];
  logic [63:0] exp_buf [2];
  logic wr_busy_a, done_a, fb_rd_a, activate_a, spi_busy_a;
  logic [4:0] fb_addr_a;
  logic [7:0] fb_data_a;
  logic [1:0] in_cs_a;
  logic [7:0] out_data_a [8];
  logic [2:0] out_count_a;
  logic wr_busy_b, done_b, fb_rd_b, activate_b, spi_busy_b;
  logic [3:0] fb_addr_b;
  logic [7:0] fb_data_b;
  logic [1:0] in_cs_b;
  logic [7:0] out_data_b [8];
  logic [2:0] out_count_b;

  always #5 clk = ~clk;

  ht16d35a_frame_writer dut_a (
    .clk(clk), .reset(reset), .start(start), .target_cs(target_cs), .wr_busy(wr_busy_a),
    .done(done_a), .fb_rd(fb_rd_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
    .activate(activate_a), .in_cs(in_cs_a), .out_data(out_data_a), .out_count(out_count_a),
    .spi_busy(spi_busy_a));

  ht16d35a_frame_writer #(.FB_BYTES(12)) dut_b (
    .clk(clk), .reset(reset), .start(start), .target_cs(target_cs), .wr_busy(wr_busy_b),
    .done(done_b), .fb_rd(fb_rd_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
    .activate(activate_b), .in_cs(in_cs_b), .out_data(out_data_b), .out_count(out_count_b),
    .spi_busy(spi_busy_b));

  // framebuffer: data one cycle after the read strobe, poison otherwise
  always @(posedge clk) begin
    fb_data_a <= fb_rd_a ? mem[fb_addr_a] : 8'hEE;
    fb_data_b <= fb_rd_b ? mem[fb_addr_b] : 8'hEE;
  end

  // controller model: busy for bl cycles starting the cycle after activate
  always @(posedge clk) begin
    bc_a <= activate_a ? bl : (bc_a > 0 ? bc_a - 1 : 0);
    bc_b <= activate_b ? bl : (bc_b > 0 ? bc_b - 1 : 0);
  end
  assign spi_busy_a = bc_a > 0 || hold_busy;
  assign spi_busy_b = bc_b > 0 || hold_busy;

  function automatic logic [63:0] pk_a();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = out_data_a[k];
    return r;
  endfunction

  function automatic logic [63:0] pk_b();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = out_data_b[k];
    return r;
  endfunction

  // transaction and done monitor
  always @(negedge clk) begin
    if (activate_a) begin
      log_a.push_back('{in_cs_a, out_count_a, pk_a()});
      checks++;
      if (spi_busy_a) begin errors++; $display("FAIL act_while_busy_a: activate=1 spi_busy=1 required activate=0"); end
    end
    if (activate_b) begin
      log_b.push_back('{in_cs_b, out_count_b, pk_b()});
      checks++;
      if (spi_busy_b) begin errors++; $display("FAIL act_while_busy_b: activate=1 spi_busy=1 required activate=0"); end
    end
    if (done_a) done_n_a++;
    if (done_b) done_n_b++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_checks(input string t);
    chk({t, "_act_a"}, 64'(activate_a), 64'd0);
    chk({t, "_wrbusy_a"}, 64'(wr_busy_a), 64'd0);
    chk({t, "_done_a"}, 64'(done_a), 64'd0);
    chk({t, "_fbrd_a"}, 64'(fb_rd_a), 64'd0);
    chk({t, "_fbaddr_a"}, 64'(fb_addr_a), 64'd0);
    chk({t, "_cs_a"}, 64'(in_cs_a), 64'd0);
    chk({t, "_cnt_a"}, 64'(out_count_a), 64'd0);
    chk({t, "_data_a"}, pk_a(), 64'd0);
    chk({t, "_act_b"}, 64'(activate_b), 64'd0);
    chk({t, "_wrbusy_b"}, 64'(wr_busy_b), 64'd0);
    chk({t, "_cnt_b"}, 64'(out_count_b), 64'd0);
    chk({t, "_data_b"}, pk_b(), 64'd0);
  endtask

  task automatic start_frame(input logic [1:0] cs);
    log_a.delete();
    log_b.delete();
    done_n_a = 0;
    done_n_b = 0;
    @(posedge clk); #1 target_cs = cs; start = 1;
    @(posedge clk); #1 start = 0; target_cs = ~cs;
    chk("wr_busy_rise_a", 64'(wr_busy_a), 64'd1);
    chk("wr_busy_rise_b", 64'(wr_busy_b), 64'd1);
  endtask

  task automatic finish_frame(input bit inject);
    int cyc = 0;
    bit inj = 0;
    while ((done_n_a == 0 || done_n_b == 0) && cyc < 5000) begin
      @(posedge clk); #1 cyc++;
      if (inject && !inj && log_a.size() == 2) begin
        repeat (3) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        inj = 1;
      end
    end
    chk("frame_timeout", 64'(cyc < 5000), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("done_count_a", 64'(done_n_a), 64'd1);
    chk("done_count_b", 64'(done_n_b), 64'd1);
    chk("wr_busy_end_a", 64'(wr_busy_a), 64'd0);
    chk("wr_busy_end_b", 64'(wr_busy_b), 64'd0);
  endtask

  task automatic verify(input int which, input int fb, input logic [1:0] cs);
    txn_t got[$];
    logic [63:0] b;
    int k = 0;
    if (which == 1) got = log_b; else got = log_a;
    b = exp_buf[which];
    for (int s = 0; s < fb; s += 6) begin
      int n;
      n = (fb - s < 6) ? fb - s : 6;
      b[7:0] = 8'h80;
      b[15:8] = 8'(s);
      for (int j = 0; j < n; j++) b[8*(j+2) +: 8] = mem[s+j];
      if (k < got.size()) begin
        chk($sformatf("txn%0d_%0d_cs", which, k), 64'(got[k].cs), 64'(cs));
        chk($sformatf("txn%0d_%0d_cnt", which, k), 64'(got[k].cnt), 64'(n + 1));
        chk($sformatf("txn%0d_%0d_data", which, k), got[k].d, b);
      end
      k++;
    end
    chk($sformatf("txn%0d_total", which), 64'(got.size()), 64'(k));
    exp_buf[which] = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    int cyc;
    tbl[0] = '{20, 2'b01, 1'b0, 1'b0, 6, 2};
    tbl[1] = '{3, 2'b10, 1'b1, 1'b0, 6, 2};
    tbl[2] = '{1, 2'b11, 1'b1, 1'b0, 6, 2};
    tbl[3] = '{20, 2'b10, 1'b1, 1'b1, 6, 2};
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);
    exp_buf[0] = '0;
    exp_buf[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset_checks("rst");
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      bl = tbl[i].bl;
      if (tbl[i].rnd) for (int j = 0; j < 32; j++) mem[j] = 8'($urandom);
      start_frame(tbl[i].cs);
      finish_frame(tbl[i].inject);
      verify(0, 32, tbl[i].cs);
      verify(1, 12, tbl[i].cs);
      chk("tbl_txns_a", 64'(log_a.size()), 64'(tbl[i].n_a));
      chk("tbl_txns_b", 64'(log_b.size()), 64'(tbl[i].n_b));
      if (i == 0 && log_a.size() == 6) begin
        chk("first_txn_data", log_a[0].d, 64'h1514131211100080);
        chk("first_txn_cnt", 64'(log_a[0].cnt), 64'd7);
        chk("last_txn_data", 64'(log_a[5].d[31:0]), 64'h2F2E1E80);
        chk("last_txn_cnt", 64'(log_a[5].cnt), 64'd3);
      end
    end
    bl = 20;
    hold_busy = 1;
    start_frame(2'b11);
    repeat (50) @(posedge clk);
    #1;
    chk("stall_no_act_a", 64'(log_a.size()), 64'd0);
    chk("stall_no_act_b", 64'(log_b.size()), 64'd0);
    hold_busy = 0;
    @(negedge clk);
    chk("stall_release_a", 64'(activate_a), 64'd1);
    chk("stall_release_b", 64'(activate_b), 64'd1);
    finish_frame(0);
    verify(0, 32, 2'b11);
    verify(1, 12, 2'b11);
    start_frame(2'b01);
    cyc = 0;
    while (log_a.size() < 3 && cyc < 2000) begin
      @(posedge clk); #1 cyc++;
    end
    chk("third_txn_wait", 64'(cyc < 2000), 64'd1);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset_checks("midrst");
    reset = 0;
    exp_buf[0] = '0;
    exp_buf[1] = '0;
    start_frame(2'b01);
    finish_frame(0);
    verify(0, 32, 2'b01);
    verify(1, 12, 2'b01);
    chk("restart_addr0", 64'(log_a.size() > 0 ? log_a[0].d[15:8] : 8'hFF), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
